lcd_spi_panel_rx: RTL and testbench

//   Panel-side receiver for the 4-wire SPI LCD link (SCK, CS, D/C, MOSI, RESX).

---
 rtl/lcd_spi_panel_rx.sv | 260 ++++++++++++++++++++++++++
 tb/tb_lcd_spi_panel_rx.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_panel_rx.sv
// lcd_spi_panel_rx
//   Panel-side receiver for a 4-wire SPI LCD link. It resynchronises the SPI
//   pins into the clk domain, assembles MSB-first bytes on rising SCK, and
//   decodes the command stream: CASET/RASET windows, RAMWR pixel data
//   (RGB565, high byte first) and the display/sleep flag commands.
//
// Ports
//   clk, resetn        system clock, synchronous active-low reset
//   lcd_clk            SPI SCK (async), data sampled on its rising edge
//   lcd_cs             chip select, active low (async)
//   lcd_rs             D/C: 0 = command, 1 = data/parameter (async)
//   lcd_data           MOSI, MSB first (async)
//   lcd_resetn         panel RESX, active low (async); acts like resetn
//   byte_valid/_data/_dc   one-cycle pulse per received byte with its D/C flag
//   pix_valid/_x/_y/_data  one-cycle pulse per completed RGB565 pixel write
//   disp_on, sleep_out     DISPON/DISPOFF and SLPOUT/SLPIN state
module lcd_spi_panel_rx #(
   parameter int XMAX    = 239,
   parameter int YMAX    = 319,
   parameter int COORD_W = 9
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               lcd_clk,
   input  logic               lcd_cs,
   input  logic               lcd_rs,
   input  logic               lcd_data,
   input  logic               lcd_resetn,
   output logic               byte_valid,
   output logic [7:0]         byte_data,
   output logic               byte_dc,
   output logic               pix_valid,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic [15:0]        pix_data,
   output logic               disp_on,
   output logic               sleep_out
);

   localparam logic [COORD_W-1:0] X_DEF = COORD_W'(XMAX);
   localparam logic [COORD_W-1:0] Y_DEF = COORD_W'(YMAX);

   typedef enum logic [1:0] {S_IDLE, S_CASET, S_RASET, S_RAMWR} state_t;

   function automatic logic [COORD_W-1:0] trunc_coord(input logic [15:0] v);
      return v[COORD_W-1:0];
   endfunction

   // ---- input synchronisers (plain data flops, no reset) ----
   logic [1:0] sck_sync_q, cs_sync_q, rs_sync_q, dat_sync_q, resx_sync_q;
   logic       sck_prev_q;

   always_ff @(posedge clk) begin
      sck_sync_q  <= {sck_sync_q[0],  lcd_clk};
      cs_sync_q   <= {cs_sync_q[0],   lcd_cs};
      rs_sync_q   <= {rs_sync_q[0],   lcd_rs};
      dat_sync_q  <= {dat_sync_q[0],  lcd_data};
      resx_sync_q <= {resx_sync_q[0], lcd_resetn};
      sck_prev_q  <= sck_sync_q[1];
   end

   // Panel RESX behaves exactly like the system reset while it is low.
   logic rst_n;
   logic sck_rise;
   assign rst_n    = resetn & resx_sync_q[1];
   assign sck_rise = sck_sync_q[1] & ~sck_prev_q;

   // ---- byte assembler ----
   logic [2:0] bit_cnt_q;
   logic [6:0] shift_q;
   logic       byte_valid_q, byte_dc_q;
   logic [7:0] byte_data_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         byte_valid_q <= 1'b0;
         byte_data_q  <= '0;
         byte_dc_q    <= 1'b0;
      end else begin
         byte_valid_q <= 1'b0;
         if (cs_sync_q[1]) begin
            // Deselect drops any partial byte.
            bit_cnt_q <= '0;
         end else if (sck_rise) begin
            shift_q   <= {shift_q[5:0], dat_sync_q[1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;  // wraps to 0 after the 8th bit
            if (bit_cnt_q == 3'd7) begin
               byte_valid_q <= 1'b1;
               byte_data_q  <= {shift_q, dat_sync_q[1]};
               byte_dc_q    <= rs_sync_q[1];
            end
         end
      end
   end

   assign byte_valid = byte_valid_q;
   assign byte_data  = byte_data_q;
   assign byte_dc    = byte_dc_q;

   // ---- command decoder ----
   state_t             state_q, state_d;
   logic [1:0]         pidx_q, pidx_d;
   logic [7:0]         p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
   logic [7:0]         hi_q, hi_d;
   logic               phase_q, phase_d;
   logic [COORD_W-1:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
   logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
   logic               pix_valid_q, pix_valid_d;
   logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic [15:0]        pix_data_q, pix_data_d;
   logic               disp_q, disp_d, slp_q, slp_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pidx_q      <= '0;
         p0_q        <= '0;
         p1_q        <= '0;
         p2_q        <= '0;
         hi_q        <= '0;
         phase_q     <= 1'b0;
         xs_q        <= '0;
         xe_q        <= X_DEF;
         ys_q        <= '0;
         ye_q        <= Y_DEF;
         cx_q        <= '0;
         cy_q        <= '0;
         pix_valid_q <= 1'b0;
         pix_x_q     <= '0;
         pix_y_q     <= '0;
         pix_data_q  <= '0;
         disp_q      <= 1'b0;
         slp_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pidx_q      <= pidx_d;
         p0_q        <= p0_d;
         p1_q        <= p1_d;
         p2_q        <= p2_d;
         hi_q        <= hi_d;
         phase_q     <= phase_d;
         xs_q        <= xs_d;
         xe_q        <= xe_d;
         ys_q        <= ys_d;
         ye_q        <= ye_d;
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         pix_valid_q <= pix_valid_d;
         pix_x_q     <= pix_x_d;
         pix_y_q     <= pix_y_d;
         pix_data_q  <= pix_data_d;
         disp_q      <= disp_d;
         slp_q       <= slp_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pidx_d      = pidx_q;
      p0_d        = p0_q;
      p1_d        = p1_q;
      p2_d        = p2_q;
      hi_d        = hi_q;
      phase_d     = phase_q;
      xs_d        = xs_q;
      xe_d        = xe_q;
      ys_d        = ys_q;
      ye_d        = ye_q;
      cx_d        = cx_q;
      cy_d        = cy_q;
      pix_valid_d = 1'b0;
      pix_x_d     = pix_x_q;
      pix_y_d     = pix_y_q;
      pix_data_d  = pix_data_q;
      disp_d      = disp_q;
      slp_d       = slp_q;

      if (byte_valid_q) begin
         if (!byte_dc_q) begin
            // Every command aborts whatever was in progress; a pending odd
            // RAMWR high byte is dropped by clearing the phase.
            state_d = S_IDLE;
            pidx_d  = '0;
            phase_d = 1'b0;
            unique case (byte_data_q)
               8'h2A: state_d = S_CASET;
               8'h2B: state_d = S_RASET;
               8'h2C: begin
                  state_d = S_RAMWR;
                  cx_d    = xs_q;
                  cy_d    = ys_q;
               end
               8'h01: begin
                  xs_d   = '0;
                  xe_d   = X_DEF;
                  ys_d   = '0;
                  ye_d   = Y_DEF;
                  disp_d = 1'b0;
                  slp_d  = 1'b0;
               end
               8'h10: slp_d  = 1'b0;
               8'h11: slp_d  = 1'b1;
               8'h28: disp_d = 1'b0;
               8'h29: disp_d = 1'b1;
               default: ;
            endcase
         end else begin
            unique case (state_q)
               S_CASET, S_RASET: begin
                  pidx_d = pidx_q + 2'd1;
                  unique case (pidx_q)
                     2'd0: p0_d = byte_data_q;
                     2'd1: p1_d = byte_data_q;
                     2'd2: p2_d = byte_data_q;
                     default: begin
                        state_d = S_IDLE;
                        if (state_q == S_CASET) begin
                           xs_d = trunc_coord({p0_q, p1_q});
                           xe_d = trunc_coord({p2_q, byte_data_q});
                        end else begin
                           ys_d = trunc_coord({p0_q, p1_q});
                           ye_d = trunc_coord({p2_q, byte_data_q});
                        end
                     end
                  endcase
               end
               S_RAMWR: begin
                  phase_d = ~phase_q;
                  if (!phase_q) begin
                     hi_d = byte_data_q;
                  end else begin
                     pix_valid_d = 1'b1;
                     pix_x_d     = cx_q;
                     pix_y_d     = cy_q;
                     pix_data_d  = {hi_q, byte_data_q};
                     // Raster advance inside the window, wrapping to the start.
                     if (cx_q < xe_q) begin
                        cx_d = cx_q + 1'b1;
                     end else begin
                        cx_d = xs_q;
                        cy_d = (cy_q < ye_q) ? cy_q + 1'b1 : ys_q;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign pix_valid = pix_valid_q;
   assign pix_x     = pix_x_q;
   assign pix_y     = pix_y_q;
   assign pix_data  = pix_data_q;
   assign disp_on   = disp_q;
   assign sleep_out = slp_q;

endmodule

// File: tb/tb_lcd_spi_panel_rx.sv
module tb_lcd_spi_panel_rx;
   localparam int XMAX = 239;
   localparam int YMAX = 319;
   localparam int CW   = 9;
   localparam int HALF = 3;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          lcd_clk = 1'b0, lcd_cs = 1'b1, lcd_rs = 1'b0, lcd_data = 1'b0;
   logic          lcd_resetn = 1'b1;
   logic          byte_valid, byte_dc, pix_valid, disp_on, sleep_out;
   logic [7:0]    byte_data;
   logic [CW-1:0] pix_x, pix_y;
   logic [15:0]   pix_data;

   lcd_spi_panel_rx #(.XMAX(XMAX), .YMAX(YMAX), .COORD_W(CW)) dut (
      .clk(clk), .resetn(resetn), .lcd_clk(lcd_clk), .lcd_cs(lcd_cs),
      .lcd_rs(lcd_rs), .lcd_data(lcd_data), .lcd_resetn(lcd_resetn),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
      .disp_on(disp_on), .sleep_out(sleep_out));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [8:0]  byte_q[$];   // {dc, byte}
   logic [33:0] pix_q[$];    // {x[8:0], y[8:0], data[15:0]}

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---- reference model: byte-level decode, pixel position from pixel index ----
   int m_state;              // 0 idle, 1 column params, 2 row params, 3 pixel data
   int m_xs, m_xe, m_ys, m_ye;
   int m_p[4];
   int m_pc, m_hi, m_n;
   bit m_has_hi, m_disp, m_slp;

   function automatic void model_reset();
      m_state = 0; m_xs = 0; m_xe = XMAX; m_ys = 0; m_ye = YMAX;
      m_pc = 0; m_has_hi = 0; m_disp = 0; m_slp = 0; m_n = 0;
   endfunction

   function automatic void model_byte(input bit dc, input logic [7:0] v);
      int w, h, x, y;
      byte_q.push_back({dc, v});
      if (!dc) begin
         m_has_hi = 0;
         m_state  = 0;
         case (v)
            8'h2A: begin m_state = 1; m_pc = 0; end
            8'h2B: begin m_state = 2; m_pc = 0; end
            8'h2C: begin m_state = 3; m_n = 0; end
            8'h01: begin
               m_xs = 0; m_xe = XMAX; m_ys = 0; m_ye = YMAX; m_disp = 0; m_slp = 0;
            end
            8'h10: m_slp = 0;
            8'h11: m_slp = 1;
            8'h28: m_disp = 0;
            8'h29: m_disp = 1;
            default: ;
         endcase
      end else if (m_state == 1 || m_state == 2) begin
         m_p[m_pc] = int'(v);
         m_pc++;
         if (m_pc == 4) begin
            if (m_state == 1) begin
               m_xs = (m_p[0] * 256 + m_p[1]) % (1 << CW);
               m_xe = (m_p[2] * 256 + m_p[3]) % (1 << CW);
            end else begin
               m_ys = (m_p[0] * 256 + m_p[1]) % (1 << CW);
               m_ye = (m_p[2] * 256 + m_p[3]) % (1 << CW);
            end
            m_state = 0;
         end
      end else if (m_state == 3) begin
         if (!m_has_hi) begin
            m_hi = int'(v); m_has_hi = 1;
         end else begin
            m_has_hi = 0;
            w = m_xe - m_xs + 1;
            h = m_ye - m_ys + 1;
            x = m_xs + (m_n % w);
            y = m_ys + ((m_n / w) % h);
            pix_q.push_back({x[CW-1:0], y[CW-1:0], m_hi[7:0], v});
            m_n++;
         end
      end
   endfunction

   // ---- SPI driver ----
   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input bit dc, input logic [7:0] v, input int nbits);
      logic [7:0] b;
      b = v;
      lcd_cs = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         lcd_clk = 1'b0; lcd_rs = dc; lcd_data = b[7 - i];
         wait_clk(HALF);
         lcd_clk = 1'b1;
         wait_clk(HALF);
      end
      lcd_clk = 1'b0;
   endtask

   task automatic send_byte(input bit dc, input logic [7:0] v);
      model_byte(dc, v);
      send_bits(dc, v, 8);
   endtask

   task automatic cs_high(input int n);
      lcd_cs = 1'b1;
      wait_clk(n);
   endtask

   task automatic send_window(input logic [7:0] cmd, input logic [7:0] hi, input int s, input int e);
      logic [7:0] sl, el;
      sl = s[7:0]; el = e[7:0];
      send_byte(0, cmd); send_byte(1, hi); send_byte(1, sl);
      send_byte(1, hi); send_byte(1, el);
   endtask

   // ---- monitor: pops the scoreboard whenever the DUT presents an output ----
   logic prev_bv = 1'b0, prev_pv = 1'b0;
   always @(negedge clk) begin
      logic [8:0]  eb;
      logic [33:0] ep;
      if (byte_valid) begin
         check("byte_pulse_width", {31'd0, prev_bv}, 32'd0);
         if (byte_q.size() == 0) begin
            check("unexpected_byte", {23'd0, byte_dc, byte_data}, 32'h1ff);
         end else begin
            eb = byte_q.pop_front();
            check("byte", {23'd0, byte_dc, byte_data}, {23'd0, eb});
         end
      end
      if (pix_valid) begin
         check("pix_pulse_width", {31'd0, prev_pv}, 32'd0);
         if (pix_q.size() == 0) begin
            check("unexpected_pixel", {pix_x, pix_y, pix_data[13:0]}, 32'hffffffff);
         end else begin
            ep = pix_q.pop_front();
            check("pix_xy", {14'd0, pix_x, pix_y}, {14'd0, ep[33:16]});
            check("pix_data", {16'd0, pix_data}, {16'd0, ep[15:0]});
         end
      end
      prev_bv <= byte_valid;
      prev_pv <= pix_valid;
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_byte"}, {22'd0, byte_valid, byte_data, byte_dc}, 32'd0);
      check({tag, "_pix"}, {pix_valid, pix_x, pix_y, pix_data[12:0]}, 32'd0);
      check({tag, "_pixhi"}, {29'd0, pix_data[15:13]}, 32'd0);
      check({tag, "_flags"}, {30'd0, disp_on, sleep_out}, 32'd0);
   endtask

   task automatic check_flags(input string tag);
      check(tag, {30'd0, disp_on, sleep_out}, {30'd0, m_disp, m_slp});
   endtask

   initial begin
      int act, k, s, e;
      logic [7:0] v, hi;
      model_reset();

      // Reset held: outputs zero, bytes shifted meanwhile are ignored.
      resetn = 1'b0;
      wait_clk(4);
      check_all_zero("reset");
      send_bits(0, 8'hFF, 8);
      cs_high(4);
      check_all_zero("reset_after_bytes");
      resetn = 1'b1;
      wait_clk(4);

      // Single command byte.
      send_byte(0, 8'hA5);
      cs_high(6);

      // Mid-byte abort then full byte.
      send_bits(1, 8'hFF, 5);
      cs_high(6);
      send_byte(0, 8'h3C);
      cs_high(6);

      // Odd data byte dropped by the next command.
      send_byte(0, 8'h2C);
      send_byte(1, 8'h12); send_byte(1, 8'h34); send_byte(1, 8'h56);
      send_byte(0, 8'h29);
      send_byte(1, 8'h78);
      send_byte(0, 8'h2C);
      send_byte(1, 8'hAB); send_byte(1, 8'hCD);
      cs_high(8);
      check_flags("odd_byte_flags");
      check("odd_disp_on", {31'd0, disp_on}, 32'd1);

      // Window and RAMWR wrap.
      send_window(8'h2A, 8'h00, 10, 11);
      send_window(8'h2B, 8'h00, 20, 21);
      send_byte(0, 8'h2C);
      send_byte(1, 8'hF8); send_byte(1, 8'h00);
      send_byte(1, 8'h07); send_byte(1, 8'hE0);
      send_byte(1, 8'h00); send_byte(1, 8'h1F);
      send_byte(1, 8'hFF); send_byte(1, 8'hFF);
      send_byte(1, 8'h12); send_byte(1, 8'h34);
      cs_high(8);

      // Flags, then panel RESX.
      send_byte(0, 8'h11);
      send_byte(0, 8'h29);
      cs_high(8);
      check("flags_set", {30'd0, disp_on, sleep_out}, 32'd3);
      lcd_resetn = 1'b0;
      wait_clk(10);
      model_reset();
      check("resx_flags", {30'd0, disp_on, sleep_out}, 32'd0);
      lcd_resetn = 1'b1;
      wait_clk(4);
      // 241 pixels: the last one wraps to the next row only if XE is back at 239.
      send_byte(0, 8'h2C);
      for (int i = 0; i < 241; i++) begin
         v = 8'($urandom_range(0, 255));
         send_byte(1, v);
         send_byte(1, 8'(i));
      end
      cs_high(8);

      // Truncation of an out-of-range coordinate to COORD_W bits.
      send_window(8'h2A, 8'h02, 5, 6);
      send_byte(0, 8'h2C);
      for (int i = 0; i < 3; i++) begin
         send_byte(1, 8'hC0); send_byte(1, 8'(i));
      end
      cs_high(6);

      // Randomised command/data mix.
      for (int a = 0; a < 40; a++) begin
         act = $urandom_range(0, 8);
         case (act)
            0, 1: begin
               hi = 8'($urandom_range(0, 1));
               s  = $urandom_range(0, 20);
               e  = s + $urandom_range(0, 3);
               send_window(act == 0 ? 8'h2A : 8'h2B, hi, s, e);
            end
            2, 3: begin
               send_byte(0, 8'h2C);
               k = $urandom_range(0, 9);
               for (int i = 0; i < k; i++) send_byte(1, 8'($urandom_range(0, 255)));
            end
            4: begin
               case ($urandom_range(0, 3))
                  0: v = 8'h10; 1: v = 8'h11; 2: v = 8'h28; default: v = 8'h29;
               endcase
               send_byte(0, v);
            end
            5: begin
               do v = 8'($urandom_range(0, 255));
               while (v inside {8'h01, 8'h10, 8'h11, 8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2C});
               send_byte(0, v);
               send_byte(1, 8'($urandom_range(0, 255)));
            end
            6: begin
               // Window command cut short by another command.
               send_byte(0, ($urandom_range(0, 1) != 0) ? 8'h2A : 8'h2B);
               send_byte(1, 8'h00); send_byte(1, 8'($urandom_range(0, 255)));
               send_byte(0, 8'h2C);
            end
            7: begin
               send_bits(1, 8'($urandom_range(0, 255)), $urandom_range(1, 7));
               cs_high($urandom_range(3, 10));
            end
            default: begin
               if ($urandom_range(0, 3) == 0) send_byte(0, 8'h01);
               else send_byte(1, 8'($urandom_range(0, 255)));
            end
         endcase
         if ($urandom_range(0, 3) == 0) cs_high($urandom_range(3, 10));
      end
      cs_high(20);

      check_flags("final_flags");
      check("bytes_outstanding", byte_q.size(), 32'd0);
      check("pixels_outstanding", pix_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
